// File: rtl/rrotate16_gen_block.sv
// 16-bit registered right-rotator built as a 4-level log barrel.
// Define RROTATE16_PIPE_EN to register after the 2-bit level (latency 2 instead of 1).
module rrotate16_level #(
  parameter int W  = 16,
  parameter int SH = 1
) (
  input  logic [W-1:0] d,
  input  logic         en,
  output logic [W-1:0] q
);
  assign q = en ? {d[SH-1:0], d[W-1:SH]} : d;
endmodule

module rrotate16_gen_block #(
  parameter logic [15:0] RST_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] A,
  input  logic [3:0]  shr,
  output logic [15:0] OUT,
  output logic        out_valid,
  output logic        zero,
  output logic        lsb_out
);
`ifdef RROTATE16_PIPE_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  logic [3:0][15:0] lvl_in;
  logic [4:1][15:0] lvl;
  logic [3:0]       lvl_en;
  logic [1:0]       shr_hi;
  logic [STAGES:1]  vld_q;
  logic [STAGES:0]  vld_pipe;

  // vld_pipe[s] is high when the data entering stage s is valid
  assign vld_pipe = {vld_q, in_valid};

`ifdef RROTATE16_PIPE_EN
  logic [15:0] p_data;
  logic [1:0]  p_shr;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_data <= '0;
      p_shr  <= '0;
    end else if (in_valid) begin
      p_data <= lvl[2];
      p_shr  <= shr[3:2];
    end
  end

  assign lvl_in[2] = p_data;
  assign shr_hi    = p_shr;
`else
  assign lvl_in[2] = lvl[2];
  assign shr_hi    = shr[3:2];
`endif

  assign lvl_in[0] = A;
  assign lvl_in[1] = lvl[1];
  assign lvl_in[3] = lvl[3];
  assign lvl_en    = {shr_hi, shr[1:0]};

  for (genvar k = 0; k < 4; k++) begin : g_lvl
    rrotate16_level #(.W(16), .SH(1 << k)) u_lvl (
      .d  (lvl_in[k]),
      .en (lvl_en[k]),
      .q  (lvl[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_pipe[STAGES-1:0];
  end

  // zero/lsb_out are captured with OUT so they only move when OUT does
  always_ff @(posedge clk) begin
    if (rst) begin
      OUT     <= RST_VAL;
      zero    <= (RST_VAL == 16'h0000);
      lsb_out <= RST_VAL[0];
    end else if (vld_pipe[STAGES-1]) begin
      OUT     <= lvl[4];
      zero    <= (lvl[4] == 16'h0000);
      lsb_out <= lvl[4][0];
    end
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_rrotate16_gen_block.sv
// Scoreboard bench for rrotate16_gen_block; expected words queued at the input edge.
module tb_rrotate16_gen_block;
`ifdef RROTATE16_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [15:0] RST_VAL = 16'h5A5B;

  logic        clk = 1'b0;
  logic        rst, in_valid;
  logic [15:0] A, OUT;
  logic [3:0]  shr;
  logic        out_valid, zero, lsb_out;

  rrotate16_gen_block #(.RST_VAL(RST_VAL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .shr(shr),
    .OUT(OUT), .out_valid(out_valid), .zero(zero), .lsb_out(lsb_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rot_ref(input logic [15:0] a, input logic [3:0] s);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = a[(i + int'(s)) % 16];
    return r;
  endfunction

  // Model: expected words and a latency shift of valid bits
  logic [15:0]    sb_q[$];
  logic [LAT-1:0] m_vld = '0;
  logic [15:0]    held;
  bit             started = 0;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      sb_q.delete();
      m_vld = '0;
      held  = RST_VAL;
    end else begin
      if (in_valid) sb_q.push_back(rot_ref(A, shr));
      m_vld = {m_vld, in_valid};
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", {15'd0, out_valid}, {15'd0, m_vld[LAT-1]});
      if (m_vld[LAT-1]) begin
        if (sb_q.size() == 0) chk("sb_underflow", 16'd1, 16'd0);
        else held = sb_q.pop_front();
      end
      chk("out", OUT, held);
      chk("zero", {15'd0, zero}, {15'd0, held == 16'h0000});
      chk("lsb", {15'd0, lsb_out}, {15'd0, held[0]});
    end
  end

  task automatic drive(input logic r, input logic v, input logic [15:0] a, input logic [3:0] s);
    rst = r; in_valid = v; A = a; shr = s;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [15:0] a, b;
    drive(1, 0, 16'h0000, 4'h0);
    drive(1, 1, 16'hFFFF, 4'h3);
    // Directed vectors
    drive(0, 1, 16'h0030, 4'h8);
    drive(0, 1, 16'h8001, 4'h1);
    drive(0, 1, 16'h8001, 4'hF);
    drive(0, 1, 16'h8001, 4'h0);
    drive(0, 1, 16'h1234, 4'h8);
    drive(0, 0, 16'hDEAD, 4'h4);
    // Walking ones across all rotate amounts
    for (int k = 0; k < 16; k++)
      for (int s = 0; s < 16; s++) begin
        a = 16'h0001 << k;
        drive(0, 1, a, 4'(s));
      end
    // Random words with occasional bubbles
    for (int n = 0; n < 8; n++)
      for (int s = 0; s < 16; s++) begin
        a = 16'($urandom);
        drive(0, 1, a, 4'(s));
        if ($urandom_range(0, 3) == 0) drive(0, 0, 16'($urandom), 4'($urandom));
      end
    // Rotate by k then 16-k must come back to the original word
    for (int n = 0; n < 4; n++) begin
      a = 16'($urandom);
      for (int k = 1; k < 16; k++) begin
        b = rot_ref(a, 4'(k));
        drive(0, 1, a, 4'(k));
        drive(0, 1, b, 4'(16 - k));
      end
    end
    // Zero result then idle hold
    drive(0, 1, 16'h0000, 4'h5);
    drive(0, 0, 16'hFFFF, 4'h1);
    drive(0, 0, 16'hFFFF, 4'h2);
    drive(0, 1, 16'h0000, 4'hC);
    // Reset mid-stream with in_valid high
    drive(0, 1, 16'hABCD, 4'h3);
    drive(0, 1, 16'h1357, 4'h7);
    drive(1, 1, 16'h2468, 4'h2);
    drive(0, 1, 16'h0F00, 4'h4);
    drive(0, 0, 16'h0000, 4'h0);
    drive(0, 1, 16'h8000, 4'hF);
    drive(0, 1, 16'h0001, 4'h1);
    for (int i = 0; i < LAT + 3; i++) drive(0, 0, 16'h0000, 4'h0);
    chk("sb_drain", 16'(sb_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
